// File: rtl/apb_i2c_pkg.sv
// Shared types and bridge register map for the APB-to-I2C master sequencer.
package apb_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RESP_OK      = 2'd0,
        RESP_SLVERR  = 2'd1,
        RESP_TIMEOUT = 2'd2,
        RESP_DECERR  = 2'd3
    } resp_t;

    localparam logic [31:0] ADDR_TX  = 32'd0;
    localparam logic [31:0] ADDR_RX  = 32'd4;
    localparam logic [31:0] ADDR_CFG = 32'd8;
    localparam logic [31:0] ADDR_TMO = 32'd12;

    // TX FIFO is write-only, RX FIFO is read-only, CONFIG/TIMEOUT are read/write.
    function automatic logic addr_legal(input logic write, input logic [31:0] addr);
        logic ok;
        ok = 1'b0;
        case (addr)
            ADDR_TX:            ok = write;
            ADDR_RX:            ok = !write;
            ADDR_CFG, ADDR_TMO: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester preferred on contention.
module apb_rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_reg;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_reg ? 2'b10 : 2'b01;
        end
    end

    // After granting requester 0 prefer 1, and vice versa.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_reg <= gnt[0];
        end
    end

endmodule

// File: rtl/apb_i2c_master_seq.sv
// APB master sequencer: arbitrates two requesters, runs SETUP/ACCESS with a bounded wait, reports a response.
module apb_i2c_master_seq
    import apb_i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        REQ,
    input  logic [1:0]        REQ_WRITE,
    input  logic [31:0]       REQ_ADDR0,
    input  logic [31:0]       REQ_ADDR1,
    input  logic [DATA_W-1:0] REQ_WDATA0,
    input  logic [DATA_W-1:0] REQ_WDATA1,
    output logic [1:0]        DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RESP,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              BUSY
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

    state_t              state_reg;
    resp_t               resp_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          done_reg;
    logic                psel_reg;
    logic                penable_reg;
    logic                pwrite_reg;
    logic [31:0]         paddr_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;

    logic [1:0]          gnt;
    logic                advance;
    logic                sel_write;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign advance = (state_reg == ST_IDLE) && (REQ != 2'b00);

    apb_rr_arb2 u_arb (
        .clk     (PCLK),
        .srst    (PRESET),
        .req     (REQ),
        .advance (advance),
        .gnt     (gnt)
    );

    assign sel_write = gnt[1] ? REQ_WRITE[1] : REQ_WRITE[0];
    assign sel_addr  = gnt[1] ? REQ_ADDR1    : REQ_ADDR0;
    assign sel_wdata = gnt[1] ? REQ_WDATA1   : REQ_WDATA0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= ST_IDLE;
            resp_reg     <= RESP_OK;
            gnt_reg      <= 2'b00;
            done_reg     <= 2'b00;
            psel_reg     <= 1'b0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            rdata_reg    <= '0;
            wait_cnt_reg <= '0;
        end else begin
            done_reg <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (advance) begin
                        gnt_reg    <= gnt;
                        paddr_reg  <= sel_addr;
                        pwdata_reg <= sel_wdata;
                        pwrite_reg <= sel_write;
                        if (addr_legal(sel_write, sel_addr)) begin
                            state_reg    <= ST_SETUP;
                            psel_reg     <= 1'b1;
                            wait_cnt_reg <= '0;
                        end else begin
                            // Illegal map access is answered locally without touching the bus.
                            state_reg <= ST_RESP;
                            resp_reg  <= RESP_DECERR;
                            done_reg  <= gnt;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        if (!pwrite_reg) begin
                            rdata_reg <= PRDATA;
                        end
                        resp_reg    <= PSLVERR ? RESP_SLVERR : RESP_OK;
                        psel_reg    <= 1'b0;
                        penable_reg <= 1'b0;
                        done_reg    <= gnt_reg;
                        state_reg   <= ST_RESP;
                    end else begin
                        if (wait_cnt_reg != CNT_MAX) begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                        if (TMO_EN && (wait_cnt_reg == CNT_LAST)) begin
                            resp_reg    <= RESP_TIMEOUT;
                            psel_reg    <= 1'b0;
                            penable_reg <= 1'b0;
                            done_reg    <= gnt_reg;
                            state_reg   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign DONE    = done_reg;
    assign RDATA   = rdata_reg;
    assign RESP    = resp_reg;
    assign PSELx   = psel_reg;
    assign PENABLE = penable_reg;
    assign PWRITE  = pwrite_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign BUSY    = (state_reg != ST_IDLE);

endmodule
